// File: rtl/periph_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// periph_bus_arbiter_if : requester-side and peripheral-side bus of the arbiter
// Revision: 1.0
// ============================================================================
interface periph_bus_arbiter_if #(
   parameter int NrMasters = 2
);
   logic [NrMasters-1:0]    req_i;
   logic [NrMasters*64-1:0] addr_i;
   logic [NrMasters-1:0]    we_i;
   logic [NrMasters*64-1:0] wdata_i;
   logic [NrMasters*8-1:0]  be_i;
   logic [NrMasters-1:0]    gnt_o;
   logic [NrMasters-1:0]    rvalid_o;
   logic [63:0]             rdata_o;
   logic                    err_o;
   logic                    per_req_o;
   logic [1:0]              per_sel_o;
   logic [63:0]             per_addr_o;
   logic                    per_we_o;
   logic [63:0]             per_wdata_o;
   logic [7:0]              per_be_o;
   logic                    per_gnt_i;
   logic                    per_rvalid_i;
   logic [63:0]             per_rdata_i;
   logic                    per_err_i;

   modport slave (
      input  req_i, addr_i, we_i, wdata_i, be_i,
      input  per_gnt_i, per_rvalid_i, per_rdata_i, per_err_i,
      output gnt_o, rvalid_o, rdata_o, err_o,
      output per_req_o, per_sel_o, per_addr_o, per_we_o, per_wdata_o, per_be_o
   );

   modport master (
      output req_i, addr_i, we_i, wdata_i, be_i,
      output per_gnt_i, per_rvalid_i, per_rdata_i, per_err_i,
      input  gnt_o, rvalid_o, rdata_o, err_o,
      input  per_req_o, per_sel_o, per_addr_o, per_we_o, per_wdata_o, per_be_o
   );
endinterface
`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
// periph_bus_arbiter : round-robin sharing of one slow-peripheral port,
//                      address decode, local error and timeout abort
// Revision: 1.0
// ============================================================================
module periph_bus_arbiter #(
   parameter int NrMasters     = 2,
   parameter int TimeoutCycles = 1024,
   parameter int CntWidth      = 11
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   periph_bus_arbiter_if.slave bus
);
   localparam int                  IdxW       = $clog2(NrMasters);
   localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TimeoutCycles);
   localparam logic [IdxW:0]       NrM        = (IdxW+1)'(NrMasters);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_ERR   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [IdxW-1:0]      ptr_q, ptr_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;
   logic [63:0]          addr_q, addr_d;
   logic [63:0]          wdata_q, wdata_d;
   logic                 we_q, we_d;
   logic [7:0]           be_q, be_d;
   logic [1:0]           sel_q, sel_d;
   logic [NrMasters-1:0] rvalid_q, rvalid_d;
   logic [63:0]          rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic                 win_valid;
   logic [IdxW-1:0]      win_idx;
   logic [IdxW:0]        cand;
   logic [63:0]          win_addr, win_wdata;
   logic                 win_we;
   logic [7:0]           win_be;
   logic                 win_mapped;
   logic [1:0]           win_sel;
   logic [NrMasters-1:0] gnt;
   logic [CntWidth-1:0]  cnt_inc;
   logic                 timed_out;

   // Scan downward so the last hit is the nearest request at or above ptr_q.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = NrMasters - 1; i >= 0; i--) begin
         cand = {1'b0, ptr_q} + (IdxW+1)'(i);
         if (cand >= NrM) begin
            cand = cand - NrM;
         end
         if (bus.req_i[cand[IdxW-1:0]]) begin
            win_valid = 1'b1;
            win_idx   = cand[IdxW-1:0];
         end
      end
   end

   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_we    = 1'b0;
      win_be    = '0;
      for (int m = 0; m < NrMasters; m++) begin
         if (win_idx == IdxW'(m)) begin
            win_addr  = bus.addr_i[64*m +: 64];
            win_wdata = bus.wdata_i[64*m +: 64];
            win_we    = bus.we_i[m];
            win_be    = bus.be_i[8*m +: 8];
         end
      end
   end

   always_comb begin
      win_mapped = 1'b1;
      win_sel    = 2'd0;
      if (win_addr >= 64'h1000_0000 && win_addr < 64'h1000_1000) begin
         win_sel = 2'd0;
      end else if (win_addr >= 64'h1800_0000 && win_addr < 64'h1800_1000) begin
         win_sel = 2'd1;
      end else if (win_addr >= 64'h2000_0000 && win_addr < 64'h2080_0000) begin
         win_sel = 2'd2;
      end else if (win_addr >= 64'h4000_0000 && win_addr < 64'h4000_1000) begin
         win_sel = 2'd3;
      end else begin
         win_mapped = 1'b0;
      end
   end

   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign timed_out = (cnt_q >= TimeoutVal);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      be_d     = be_q;
      sel_d    = sel_q;
      rdata_d  = rdata_q;
      rvalid_d = '0;
      err_d    = 1'b0;
      gnt      = '0;
      unique case (state_q)
         S_IDLE: begin
            if (win_valid) begin
               gnt[win_idx] = 1'b1;
               idx_d        = win_idx;
               addr_d       = win_addr;
               wdata_d      = win_wdata;
               we_d         = win_we;
               be_d         = win_be;
               sel_d        = win_sel;
               cnt_d        = '0;
               ptr_d        = (win_idx == IdxW'(NrMasters - 1)) ? '0 : win_idx + 1'b1;
               if (win_mapped) begin
                  state_d = S_ISSUE;
               end else begin
                  state_d           = S_ERR;
                  rvalid_d[win_idx] = 1'b1;
                  rdata_d           = '0;
                  err_d             = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_inc;
            if (timed_out) begin
               state_d         = S_ERR;
               rvalid_d[idx_q] = 1'b1;
               rdata_d         = '0;
               err_d           = 1'b1;
            end else if (bus.per_gnt_i) begin
               if (bus.per_rvalid_i) begin
                  state_d         = S_RESP;
                  rvalid_d[idx_q] = 1'b1;
                  rdata_d         = bus.per_rdata_i;
                  err_d           = bus.per_err_i;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            // A response landing on the timeout cycle still wins over the abort.
            if (bus.per_rvalid_i) begin
               state_d         = S_RESP;
               rvalid_d[idx_q] = 1'b1;
               rdata_d         = bus.per_rdata_i;
               err_d           = bus.per_err_i;
            end else if (timed_out) begin
               state_d         = S_ERR;
               rvalid_d[idx_q] = 1'b1;
               rdata_d         = '0;
               err_d           = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         sel_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         be_q     <= be_d;
         sel_q    <= sel_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign bus.gnt_o       = gnt;
   assign bus.rvalid_o    = rvalid_q;
   assign bus.rdata_o     = rdata_q;
   assign bus.err_o       = err_q;
   assign bus.per_req_o   = (state_q == S_ISSUE) && !timed_out;
   assign bus.per_sel_o   = sel_q;
   assign bus.per_addr_o  = addr_q;
   assign bus.per_we_o    = we_q;
   assign bus.per_wdata_o = wdata_q;
   assign bus.per_be_o    = be_q;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_periph_bus_arbiter : directed and random transactions checked against a
//                         transaction-level model of the arbiter
// Revision: 1.0
// ============================================================================
module tb_periph_bus_arbiter;
   localparam int N  = 3;
   localparam int TO = 8;
   localparam int CW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   periph_bus_arbiter_if #(.NrMasters(N)) bus ();

   periph_bus_arbiter #(
      .NrMasters    (N),
      .TimeoutCycles(TO),
      .CntWidth     (CW)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int          err_cnt = 0;
   int          chk_cnt = 0;
   bit          pend   [N];
   logic [63:0] paddr  [N];
   logic [63:0] pwdata [N];
   logic        pwe    [N];
   logic [7:0]  pbe    [N];
   int          ptr;
   logic [63:0] last_rdata;
   logic [63:0] rbase [4] = '{64'h1000_0000, 64'h1800_0000, 64'h2000_0000, 64'h4000_0000};
   logic [63:0] rlen  [4] = '{64'h1000, 64'h1000, 64'h80_0000, 64'h1000};
   logic [63:0] unmap [6] = '{64'h5000_0000, 64'h0, 64'h1000_1000, 64'h0FFF_FFFF,
                              64'h1_1000_0000, 64'h2080_0000};

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   function automatic int region(input logic [63:0] a);
      region = -1;
      for (int r = 0; r < 4; r++) begin
         if (a >= rbase[r] && a < rbase[r] + rlen[r]) region = r;
      end
   endfunction

   function automatic logic [63:0] gen_addr();
      int r;
      int k;
      r = $urandom_range(0, 5);
      k = $urandom_range(0, 3);
      if (r >= 4) return unmap[$urandom_range(0, 5)];
      if (k == 0) return rbase[r];
      if (k == 1) return rbase[r] + rlen[r] - 1;
      return rbase[r] + (64'($urandom) % rlen[r]);
   endfunction

   task automatic new_req(input int m, input logic [63:0] a);
      pend[m]   = 1'b1;
      paddr[m]  = a;
      pwe[m]    = 1'($urandom);
      pwdata[m] = {$urandom, $urandom};
      pbe[m]    = 8'($urandom);
   endtask

   task automatic drive_reqs();
      for (int m = 0; m < N; m++) begin
         bus.req_i[m]             = pend[m];
         bus.addr_i[64*m +: 64]   = paddr[m];
         bus.we_i[m]              = pwe[m];
         bus.wdata_i[64*m +: 64]  = pwdata[m];
         bus.be_i[8*m +: 8]       = pbe[m];
      end
   endtask

   // One arbitration round; returns at the negedge of the response cycle
   // (or right after reset when abort_at hits).
   task automatic run_txn(input int gdel, input int rdel, input bit no_gnt, input bit no_rsp,
                          input logic [63:0] prd, input bit perr, input int abort_at,
                          output int win);
      int          w;
      int          sel;
      int          resp_j;
      bit          is_err;
      bit          req_exp;
      logic [63:0] rd_exp;
      logic [138:0] fexp;
      @(negedge clk);
      drive_reqs();
      bus.per_gnt_i    = 1'b0;
      bus.per_rvalid_i = 1'b0;
      #1;
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && pend[(ptr + k) % N]) w = (ptr + k) % N;
      end
      win = w;
      if (w < 0) return;
      check("gnt", bus.gnt_o, 1 << w);
      check("rv_idle", bus.rvalid_o, 0);
      check("rd_hold", bus.rdata_o, last_rdata);
      sel     = region(paddr[w]);
      fexp    = {paddr[w], pwe[w], pwdata[w], pbe[w], 2'(sel)};
      ptr     = (w + 1) % N;
      pend[w] = 1'b0;
      is_err  = (sel < 0) || no_gnt || no_rsp;
      resp_j  = (sel < 0) ? 0 : (no_gnt || no_rsp) ? TO + 1 : gdel + rdel + 1;
      for (int j = 0; j <= resp_j; j++) begin
         @(negedge clk);
         drive_reqs();
         bus.per_gnt_i    = (sel >= 0) && !no_gnt && (j == gdel);
         bus.per_rvalid_i = (sel >= 0) && ((!no_gnt && !no_rsp && j == gdel + rdel) ||
                                           ((no_gnt || no_rsp) && j == resp_j));
         bus.per_rdata_i  = bus.per_rvalid_i ? prd : {$urandom, $urandom};
         bus.per_err_i    = perr;
         if (j == abort_at) begin
            bus.req_i = '0;
            #2 rst_n = 1'b0;
            #1;
            check("rst_outs", {bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.err_o, bus.per_req_o,
                               bus.per_sel_o, bus.per_addr_o, bus.per_we_o, bus.per_wdata_o,
                               bus.per_be_o}, 0);
            ptr        = 0;
            last_rdata = '0;
            for (int m = 0; m < N; m++) pend[m] = 1'b0;
            bus.per_gnt_i    = 1'b0;
            bus.per_rvalid_i = 1'b0;
            return;
         end
         #1;
         if (j == resp_j) begin
            rd_exp = is_err ? 64'h0 : prd;
            check("rvalid", bus.rvalid_o, 1 << w);
            check("err", bus.err_o, is_err ? 1'b1 : perr);
            check("rdata", bus.rdata_o, rd_exp);
            check("req_resp", bus.per_req_o, 0);
            check("gnt_resp", bus.gnt_o, 0);
            last_rdata = rd_exp;
         end else begin
            req_exp = (j < TO) && (no_gnt || j <= gdel);
            check("per_req", bus.per_req_o, req_exp);
            check("rv_busy", bus.rvalid_o, 0);
            check("gnt_busy", bus.gnt_o, 0);
            if (req_exp) begin
               check("fields", {bus.per_addr_o, bus.per_we_o, bus.per_wdata_o, bus.per_be_o,
                                 bus.per_sel_o}, fexp);
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int w;
      int kind;
      bit any;
      bus.req_i = '0; bus.addr_i = '0; bus.we_i = '0; bus.wdata_i = '0; bus.be_i = '0;
      bus.per_gnt_i = 1'b0; bus.per_rvalid_i = 1'b0; bus.per_rdata_i = '0; bus.per_err_i = 1'b0;
      for (int m = 0; m < N; m++) begin
         pend[m] = 1'b0; paddr[m] = '0; pwdata[m] = '0; pwe[m] = 1'b0; pbe[m] = '0;
      end
      ptr        = 0;
      last_rdata = '0;

      #2 rst_n = 1'b0;
      #1;
      check("reset_outs", {bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.err_o, bus.per_req_o,
                           bus.per_sel_o, bus.per_addr_o, bus.per_we_o, bus.per_wdata_o,
                           bus.per_be_o}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Master 0 read from UART, zero-wait peripheral
      new_req(0, 64'h1000_0004);
      pwe[0] = 1'b0;
      run_txn(0, 0, 0, 0, 64'hDEAD_BEEF_0123_4567, 1'b0, -1, w);

      // Masters 0 and 1 request continuously
      for (int i = 0; i < 6; i++) begin
         if (!pend[0]) new_req(0, 64'h1800_0010);
         if (!pend[1]) new_req(1, 64'h2000_0100);
         run_txn(i % 2, 0, 0, 0, {$urandom, $urandom}, 1'b0, -1, w);
      end
      for (int m = 0; m < N; m++) pend[m] = 1'b0;

      // Master 1 unmapped access
      new_req(1, 64'h5000_0000);
      run_txn(0, 0, 0, 0, 64'h0, 1'b0, -1, w);

      // GPIO write with delayed peripheral grant
      new_req(2, 64'h4000_0008);
      pwe[2] = 1'b1;
      pbe[2] = 8'h0F;
      run_txn(3, 2, 0, 0, 64'h1111_2222_3333_4444, 1'b0, -1, w);

      // Peripheral never responds, then a late rvalid must be ignored
      new_req(0, 64'h1800_0000);
      run_txn(0, 0, 1, 0, 64'h0, 1'b0, -1, w);
      @(negedge clk);
      bus.per_rvalid_i = 1'b1;
      bus.per_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      bus.per_rvalid_i = 1'b0;
      #1;
      check("late_rv", bus.rvalid_o, 0);
      check("late_rd", bus.rdata_o, last_rdata);

      // Granted but never answered
      new_req(1, 64'h2000_0000);
      run_txn(1, 0, 0, 1, 64'h0, 1'b0, -1, w);

      // Reset while waiting for the response
      new_req(0, 64'h1000_0ff8);
      run_txn(0, 5, 0, 0, 64'h5555, 1'b0, 2, w);
      @(negedge clk);
      rst_n = 1'b1;
      new_req(0, 64'h1000_0000);
      new_req(1, 64'h4000_0000);
      run_txn(0, 0, 0, 0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, -1, w);
      run_txn(1, 1, 0, 0, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1, -1, w);

      // Random traffic
      for (int it = 0; it < 150; it++) begin
         any = 1'b0;
         for (int m = 0; m < N; m++) begin
            if (!pend[m] && $urandom_range(0, 1) == 1) new_req(m, gen_addr());
            any |= pend[m];
         end
         if (!any) new_req($urandom_range(0, N - 1), gen_addr());
         kind = $urandom_range(0, 9);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.req_i = '0;
         end
         run_txn($urandom_range(0, 4), $urandom_range(0, 3), kind == 0, kind == 1,
                 {$urandom, $urandom}, 1'($urandom), -1, w);
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single slow-peripheral request port among NrMasters requesters; default masters are harts plus the debug module.
- Serves the UART, Timer, SPI and GPIO regions using round-robin arbitration with one transaction in flight.
- Decodes the address to a peripheral select and answers unmapped addresses locally with an error.
- A timeout counter aborts a stalled peripheral and returns an error response.

Parameters:
- NrMasters, 2, number of requesters (≥2).
- TimeoutCycles, 1024, cycles allowed from issue to peripheral response.
- CntWidth, 11, timeout counter width (≥ $clog2(TimeoutCycles+1)).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NrMasters  per-master request
- addr_i  in  NrMasters*64  per-master address (master m at [64m+63:64m])
- we_i  in  NrMasters  per-master write enable
- wdata_i  in  NrMasters*64  per-master write data
- be_i  in  NrMasters*8  per-master byte enables
- gnt_o  out  NrMasters  one-hot grant
- rvalid_o  out  NrMasters  one-hot response valid
- rdata_o  out  64  response data (shared)
- err_o  out  1  response error, qualified by any rvalid_o
- per_req_o  out  1  downstream request
- per_sel_o  out  2  peripheral: 0 UART, 1 Timer, 2 SPI, 3 GPIO
- per_addr_o  out  64  downstream address
- per_we_o  out  1  downstream write enable
- per_wdata_o  out  64  downstream write data
- per_be_o  out  8  downstream byte enables
- per_gnt_i  in  1  downstream grant
- per_rvalid_i  in  1  downstream response valid
- per_rdata_i  in  64  downstream read data
- per_err_i  in  1  downstream error

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low, rst_ni.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- Address map (region hit when base ≤ addr < base+len):
  - UART 0x1000_0000 / 0x1000
  - Timer 0x1800_0000 / 0x1000
  - SPI 0x2000_0000 / 0x80_0000
  - GPIO 0x4000_0000 / 0x1000
  - Any other address is unmapped.
- Arbitration (IDLE only):
  - Winner is the first asserted req_i at or above pointer, searching upward with wrap.
  - gnt_o[winner] is combinational in the same cycle; no other gnt_o bit asserts.
  - The winner's addr/we/wdata/be, the winner index and the decoded select are latched.
  - Pointer becomes (winner+1) mod NrMasters.
  - gnt_o is 0 in every non-IDLE state.
- States:
  - IDLE: on grant, go to ISSUE if the address is mapped, else ERR.
  - ISSUE: per_req_o=1 with the latched fields stable. Stay until per_gnt_i=1, then go to WAIT. per_rvalid_i in the same cycle as per_gnt_i is legal: complete directly to RESP.
  - WAIT: per_req_o=0. On per_rvalid_i=1, capture per_rdata_i and per_err_i and go to RESP.
  - RESP: rvalid_o[latched index]=1, rdata_o=captured data, err_o=captured err, for exactly one cycle. Then IDLE.
  - ERR: rvalid_o[index]=1, rdata_o=0, err_o=1, for exactly one cycle. Then IDLE. No downstream activity.
- Latency:
  - Mapped access, zero-wait peripheral (grant and rvalid in the first ISSUE cycle): response 2 cycles after the grant cycle.
  - Unmapped access: response 1 cycle after the grant cycle.
- Timeout:
  - Counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT.
  - When it reaches TimeoutCycles without a response, per_req_o drops and the state goes to ERR (error response, rdata 0).
  - A per_rvalid_i arriving outside WAIT/ISSUE is ignored.
  - Counter saturates and never wraps.
- Outputs: rvalid_o, rdata_o and err_o are registered. rdata_o holds its last value when rvalid_o=0.
- Simultaneous events: a new request is not granted in the RESP/ERR cycle; the earliest next grant is the following IDLE cycle.
- Reset mid-transaction drops per_req_o immediately and discards the transaction; no response is generated.
- Requesters hold req_i and fields until granted; deasserting req_i before grant is legal and is simply not arbitrated.

Test Plan:
- Master 0 reads 0x1000_0004 from a zero-wait peripheral:
  - gnt_o=01 in cycle 0.
  - per_sel_o=0 and per_req_o=1 in cycle 1.
  - rvalid_o=01 in cycle 2 with rdata_o=per_rdata_i and err_o=0.
- Masters 0 and 1 request continuously:
  - Grants alternate 01, 10, 01, …
  - No master is granted twice in a row while the other is waiting.
- Master 1 accesses 0x5000_0000:
  - per_req_o stays 0.
  - rvalid_o=10, err_o=1 and rdata_o=0 one cycle after grant.
- GPIO write 0x4000_0008, be=0x0F, per_gnt_i delayed 3 cycles:
  - per_req_o held 3 cycles with stable fields, per_be_o=0x0F and per_sel_o=3.
  - Response follows per_rvalid_i by one cycle.
- TimeoutCycles=8, peripheral never responds:
  - per_req_o drops after 8 cycles.
  - err_o=1 response on the next cycle.
  - A late per_rvalid_i is ignored; rvalid_o stays 0.
- Reset asserted in WAIT:
  - All outputs 0 immediately and pointer 0.
  - After release, a master 1 request is granted and completes normally.
